// File: rtl/ur_pkg.sv
// Shared types and helpers for the ur_rand_bank random-data source.
package ur_pkg;

  typedef enum logic [1:0] {
    OpGen  = 2'd0,
    OpRdbk = 2'd1,
    OpWr   = 2'd2,
    OpRsv  = 2'd3
  } ur_op_e;

  typedef enum logic [3:0] {
    ErrNone   = 4'd0,
    ErrInvert = 4'd1,
    ErrZero   = 4'd2,
    ErrOnes   = 4'd3,
    ErrRotl   = 4'd4,
    ErrInc    = 4'd5
  } ur_err_e;

  // Helpers operate on a 64-bit container; callers truncate to their LFSR width (<= 64).
  localparam int unsigned LfsrMaxW = 64;

  function automatic logic [LfsrMaxW-1:0] width_mask(input int unsigned width);
    return (width >= LfsrMaxW) ? '1 : ((64'd1 << width) - 64'd1);
  endfunction

  // One Fibonacci step: shift left, feedback = parity of tapped bits into bit 0.
  function automatic logic [LfsrMaxW-1:0] lfsr_step(input logic [LfsrMaxW-1:0] state,
                                                    input logic [LfsrMaxW-1:0] poly,
                                                    input int unsigned         width);
    logic [LfsrMaxW-1:0] mask;
    logic                fb;
    mask = width_mask(width);
    fb   = ^(state & poly & mask);
    return ((state << 1) | {{(LfsrMaxW-1){1'b0}}, fb}) & mask;
  endfunction

  // Per-channel reset state so channels start decorrelated.
  function automatic logic [LfsrMaxW-1:0] seed_init(input int unsigned idx,
                                                    input int unsigned width);
    logic [LfsrMaxW-1:0] i64;
    i64 = LfsrMaxW'(idx);
    return (~64'd0 ^ (i64 << 8) ^ (i64 << 16) ^ (i64 << 24)) & width_mask(width);
  endfunction

endpackage

// File: rtl/ur_rand_bank_rsp_fifo.sv
// Response FIFO for ur_rand_bank: synchronous, flop storage, head read from flops.
module ur_rsp_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2,
  localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [CntW-1:0]  count
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] store_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_pop, do_push;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // A push into a full FIFO is legal when the head leaves in the same cycle.
  always_comb begin
    do_pop  = pop && (count_q != '0);
    do_push = push && ((count_q < CntW'(DEPTH)) || do_pop);
  end

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) store_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        store_q[wr_ptr_q] <= push_data;
        wr_ptr_q          <= ptr_inc(wr_ptr_q);
      end
      if (do_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (do_push && !do_pop) count_q <= count_q + 1'b1;
      else if (do_pop && !do_push) count_q <= count_q - 1'b1;
    end
  end

  assign out_valid = (count_q != '0);
  assign out_data  = store_q[rd_ptr_q];
  assign count     = count_q;

endmodule

// File: rtl/ur_rand_bank.sv
// Multi-channel LFSR random-data source with backing word memory and response FIFO.
// Optional error injection on GEN data is enabled with `define UR_ERR_INJ_EN.
module ur_rand_bank
  import ur_pkg::*;
#(
  parameter int unsigned            DATA_WIDTH = 128,
  parameter int unsigned            LFSR_WIDTH = 32,
  parameter logic [LFSR_WIDTH-1:0]  LFSR_POLY  = 32'h80200003,
  parameter int unsigned            ADDR_WIDTH = 11,
  parameter int unsigned            NUM_CH     = 16,
  parameter int unsigned            RSP_DEPTH  = 2,
  localparam int unsigned           IdW        = $clog2(NUM_CH),
  localparam int unsigned           StrbW      = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_op,
  input  logic [IdW-1:0]        req_id,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [StrbW-1:0]      req_wstrb,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic [IdW-1:0]        rsp_id,
  input  logic                  seed_we,
  input  logic [IdW-1:0]        seed_id,
  input  logic [LFSR_WIDTH-1:0] seed_val,
  output logic [31:0]           rd_count,
  output logic [31:0]           wr_count
`ifdef UR_ERR_INJ_EN
  ,
  input  logic                  err_inject,
  input  logic [3:0]            err_type,
  input  logic [ADDR_WIDTH-1:0] err_addr_mask,
  output logic [31:0]           err_count
`endif
);

  localparam int unsigned NumSteps = DATA_WIDTH / LFSR_WIDTH;
  localparam int unsigned MemDepth = 2 ** ADDR_WIDTH;
  localparam int unsigned CntW     = $clog2(RSP_DEPTH + 1);

  function automatic logic [LFSR_WIDTH-1:0] step(input logic [LFSR_WIDTH-1:0] s);
    logic [LfsrMaxW-1:0] r;
    r = lfsr_step(LfsrMaxW'(s), LfsrMaxW'(LFSR_POLY), LFSR_WIDTH);
    return r[LFSR_WIDTH-1:0];
  endfunction

  function automatic logic [LFSR_WIDTH-1:0] reset_state(input int unsigned idx);
    logic [LfsrMaxW-1:0] r;
    r = seed_init(idx, LFSR_WIDTH);
    return r[LFSR_WIDTH-1:0];
  endfunction

  logic [LFSR_WIDTH-1:0] lfsr_q [NUM_CH];
  logic [DATA_WIDTH-1:0] mem [MemDepth];

  ur_op_e                op;
  logic                  id_ok, req_fire, gen_fire, push;
  logic [CntW-1:0]       fifo_count;
  logic [LFSR_WIDTH-1:0] lfsr_cur, lfsr_nxt;
  logic [DATA_WIDTH-1:0] gen_word, gen_final, rd_word, push_word;
  logic                  mem_we;
  logic [StrbW-1:0]      mem_be;
  logic [DATA_WIDTH-1:0] mem_wdata;

  assign op        = ur_op_e'(req_op);
  assign id_ok     = (32'(req_id) < NUM_CH);
  // Ready depends only on registered occupancy, never on rsp_ready.
  assign req_ready = (fifo_count < CntW'(RSP_DEPTH));
  assign req_fire  = req_valid && req_ready;
  assign gen_fire  = req_fire && (op == OpGen) && id_ok;
  assign push      = req_fire && ((op == OpGen) || (op == OpRdbk));
  assign rd_word   = mem[req_addr];

  // Build the GEN word from successive LFSR steps, first state in the LSBs.
  always_comb begin
    lfsr_cur = id_ok ? lfsr_q[req_id] : '0;
    gen_word = '0;
    lfsr_nxt = lfsr_cur;
    for (int k = 0; k < int'(NumSteps); k++) begin
      gen_word[k*LFSR_WIDTH +: LFSR_WIDTH] = lfsr_nxt;
      lfsr_nxt = step(lfsr_nxt);
    end
  end

`ifdef UR_ERR_INJ_EN
  logic [3:0]            err_type_q;
  logic [ADDR_WIDTH-1:0] err_mask_q;
  logic                  err_hit;

  // Corrupt in-range GEN data when the address matches the latched mask.
  always_comb begin
    gen_final = gen_word;
    err_hit   = 1'b0;
    if (id_ok && ((req_addr & err_mask_q) == '0)) begin
      err_hit = 1'b1;
      case (err_type_q)
        ErrInvert: gen_final = ~gen_word;
        ErrZero:   gen_final = '0;
        ErrOnes:   gen_final = '1;
        ErrRotl:   gen_final = {gen_word[DATA_WIDTH-2:0], gen_word[DATA_WIDTH-1]};
        ErrInc:    gen_final = gen_word + 1'b1;
        default:   err_hit   = 1'b0;
      endcase
    end
  end

  // Error settings persist until reset; count corrupted GENs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_type_q <= 4'(ErrNone);
      err_mask_q <= '0;
      err_count  <= '0;
    end else begin
      if (err_inject) begin
        err_type_q <= err_type;
        err_mask_q <= err_addr_mask;
      end
      if (gen_fire && err_hit) err_count <= err_count + 32'd1;
    end
  end
`else
  assign gen_final = gen_word;
`endif

  // Out-of-range ids answer zeros and leave memory and LFSRs alone.
  always_comb begin
    push_word = (op == OpGen) ? gen_final : rd_word;
    if (!id_ok) push_word = '0;
    mem_we    = gen_fire || (req_fire && (op == OpWr));
    mem_be    = (op == OpWr) ? req_wstrb : '1;
    mem_wdata = (op == OpWr) ? req_wdata : gen_final;
  end

  // Byte-strobed memory write; memory is deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < int'(StrbW); b++) begin
        if (mem_be[b]) mem[req_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  // Per-channel LFSR state; a seed on the same channel overrides the GEN advance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NUM_CH); i++) lfsr_q[i] <= reset_state(i);
    end else begin
      for (int i = 0; i < int'(NUM_CH); i++) begin
        if (seed_we && (seed_id == IdW'(i))) begin
          lfsr_q[i] <= (seed_val == '0) ? '1 : seed_val;
        end else if (gen_fire && (req_id == IdW'(i))) begin
          lfsr_q[i] <= lfsr_nxt;
        end
      end
    end
  end

  // Accepted-request counters, wrapping at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_count <= '0;
      wr_count <= '0;
    end else begin
      if (push) rd_count <= rd_count + 32'd1;
      if (req_fire && (op == OpWr)) wr_count <= wr_count + 32'd1;
    end
  end

  ur_rsp_fifo #(
    .WIDTH(DATA_WIDTH + IdW),
    .DEPTH(RSP_DEPTH)
  ) u_rsp_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_data({req_id, push_word}),
    .pop      (rsp_ready),
    .out_valid(rsp_valid),
    .out_data ({rsp_id, rsp_data}),
    .count    (fifo_count)
  );

endmodule

// File: tb/tb_ur_rand_bank.sv
// Self-checking bench for ur_rand_bank: directed cases plus randomized traffic vs a model.
module tb_ur_rand_bank;

  localparam int DW = 128;
  localparam int DEPTH = 2;
  localparam logic [31:0] POLY = 32'h80200003;
  localparam logic [127:0] RESET_WORD = 128'hFFFFFFFB_FFFFFFFD_FFFFFFFE_FFFFFFFF;
  localparam logic [127:0] INV_WORD   = 128'h00000004_00000002_00000001_00000000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [1:0]    req_op = '0;
  logic [3:0]    req_id = '0;
  logic [10:0]   req_addr = '0;
  logic [127:0]  req_wdata = '0;
  logic [15:0]   req_wstrb = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [127:0]  rsp_data;
  logic [3:0]    rsp_id;
  logic          seed_we = 1'b0;
  logic [3:0]    seed_id = '0;
  logic [31:0]   seed_val = '0;
  logic [31:0]   rd_count, wr_count;
`ifdef UR_ERR_INJ_EN
  logic          err_inject = 1'b0;
  logic [3:0]    err_type = '0;
  logic [10:0]   err_addr_mask = '0;
  logic [31:0]   err_count;
`endif

  ur_rand_bank dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_op   (req_op),
    .req_id   (req_id),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data (rsp_data),
    .rsp_id   (rsp_id),
    .seed_we  (seed_we),
    .seed_id  (seed_id),
    .seed_val (seed_val),
    .rd_count (rd_count),
`ifdef UR_ERR_INJ_EN
    .err_inject   (err_inject),
    .err_type     (err_type),
    .err_addr_mask(err_addr_mask),
    .err_count    (err_count),
`endif
    .wr_count (wr_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] mstep(input logic [31:0] s);
    return (s << 1) | 32'($countones(s & POLY) % 2);
  endfunction

  function automatic logic [127:0] gen_word(input logic [31:0] s);
    logic [127:0] w;
    for (int k = 0; k < 4; k++) begin
      w[32*k +: 32] = s;
      s = mstep(s);
    end
    return w;
  endfunction

  function automatic logic [31:0] after_gen(input logic [31:0] s);
    for (int k = 0; k < 4; k++) s = mstep(s);
    return s;
  endfunction

  function automatic logic [127:0] corrupt(input logic [127:0] w, input logic [3:0] t);
    case (t)
      4'd1: return ~w;
      4'd2: return '0;
      4'd3: return '1;
      4'd4: return {w[126:0], w[127]};
      4'd5: return w + 128'd1;
      default: return w;
    endcase
  endfunction

  typedef struct {
    logic [3:0]   id;
    logic [127:0] data;
    logic [127:0] known;
  } rsp_t;

  rsp_t         mq[$];
  logic [31:0]  m_lfsr[16];
  logic [127:0] m_mem[int];
  logic [127:0] m_known[int];
  logic [31:0]  m_rdc, m_wrc, m_errc;
  logic [3:0]   m_etype;
  logic [10:0]  m_emask;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      for (int i = 0; i < 16; i++)
        m_lfsr[i] = 32'hFFFFFFFF ^ (i << 8) ^ (i << 16) ^ (i << 24);
      mq.delete();
      m_rdc = 0; m_wrc = 0; m_errc = 0; m_etype = 0; m_emask = 0;
    end else begin
      rsp_t   item;
      bit     do_push, do_pop;
      int     a;
      do_pop  = (mq.size() > 0) && rsp_ready;
      do_push = 0;
      a = int'(req_addr);
      if (req_valid && mq.size() < DEPTH) begin
        item.id = req_id;
        case (req_op)
          2'd0: begin
            m_rdc++;
            item.data = gen_word(m_lfsr[req_id]);
            m_lfsr[req_id] = after_gen(m_lfsr[req_id]);
            if (((a & int'(m_emask)) == 0) && m_etype >= 1 && m_etype <= 5) begin
              item.data = corrupt(item.data, m_etype);
              m_errc++;
            end
            item.known = '1;
            m_mem[a] = item.data;
            m_known[a] = '1;
            do_push = 1;
          end
          2'd1: begin
            m_rdc++;
            if (m_mem.exists(a)) begin
              item.data = m_mem[a]; item.known = m_known[a];
            end else begin
              item.data = '0; item.known = '0;
            end
            do_push = 1;
          end
          2'd2: begin
            m_wrc++;
            if (!m_mem.exists(a)) begin m_mem[a] = '0; m_known[a] = '0; end
            for (int b = 0; b < 16; b++) if (req_wstrb[b]) begin
              m_mem[a][8*b +: 8] = req_wdata[8*b +: 8];
              m_known[a][8*b +: 8] = 8'hFF;
            end
          end
          default: ;
        endcase
      end
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back(item);
      if (seed_we) m_lfsr[seed_id] = (seed_val == 0) ? 32'hFFFFFFFF : seed_val;
`ifdef UR_ERR_INJ_EN
      if (err_inject) begin m_etype = err_type; m_emask = err_addr_mask; end
`endif
    end
  end

  // Cycle monitor: handshake state, head of queue and counters.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      check_eq("req_ready", 128'(req_ready), 128'(mq.size() < DEPTH));
      check_eq("rsp_valid", 128'(rsp_valid), 128'(mq.size() != 0));
      if (mq.size() != 0) begin
        check_eq("rsp_data", rsp_data & mq[0].known, mq[0].data & mq[0].known);
        check_eq("rsp_id", 128'(rsp_id), 128'(mq[0].id));
      end
      check_eq("rd_count", 128'(rd_count), 128'(m_rdc));
      check_eq("wr_count", 128'(wr_count), 128'(m_wrc));
`ifdef UR_ERR_INJ_EN
      check_eq("err_count", 128'(err_count), 128'(m_errc));
`endif
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [1:0] op, input logic [3:0] id, input logic [10:0] addr,
                      input logic [127:0] wdata, input logic [15:0] wstrb);
    bit acc;
    req_valid = 1; req_op = op; req_id = id; req_addr = addr;
    req_wdata = wdata; req_wstrb = wstrb;
    for (int t = 0; t < 64; t++) begin
      @(negedge clk);
      acc = req_ready;
      @(posedge clk); #1;
      if (acc) begin req_valid = 0; return; end
    end
    check_eq("req_timeout", 128'd0, 128'd1);
    req_valid = 0;
  endtask

  task automatic gen(input logic [3:0] id, input logic [10:0] addr);
    send(2'd0, id, addr, '0, '0);
  endtask

  task automatic drain();
    rsp_ready = 1;
    for (int t = 0; t < 64; t++) begin
      if (mq.size() == 0) return;
      @(posedge clk); #1;
    end
    check_eq("drain_timeout", 128'(mq.size()), 128'd0);
  endtask

  task automatic seed(input logic [3:0] id, input logic [31:0] val);
    seed_we = 1; seed_id = id; seed_val = val;
    @(posedge clk); #1;
    seed_we = 0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [31:0] rdc0;
    bit rand_done;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_rsp_valid", 128'(rsp_valid), 128'd0);
    check_eq("rst_rsp_data", rsp_data, 128'd0);
    check_eq("rst_rsp_id", 128'(rsp_id), 128'd0);
    check_eq("rst_rd_count", 128'(rd_count), 128'd0);
    check_eq("rst_wr_count", 128'(wr_count), 128'd0);
    rst_n = 1;
    @(posedge clk); #1;

    // GEN from reset state, then readback of the captured word.
    gen(4'd0, 11'h20);
    check_eq("gen0_data", rsp_data, RESET_WORD);
    check_eq("gen0_id", 128'(rsp_id), 128'd0);
    drain();
    send(2'd1, 4'd0, 11'h20, '0, '0);
    check_eq("rdbk20", rsp_data, RESET_WORD);
    check_eq("rd_count2", 128'(rd_count), 128'd2);
    drain();

    // Strobed write then readback.
    send(2'd2, 4'd0, 11'h5, {16{8'hAA}}, 16'h000F);
    check_eq("wr_no_rsp", 128'(rsp_valid), 128'd0);
    check_eq("wr_count1", 128'(wr_count), 128'd1);
    send(2'd1, 4'd0, 11'h5, '0, '0);
    check_eq("rdbk5_lo", 128'(rsp_data[31:0]), 128'hAAAAAAAA);
    drain();

    // Backpressure with a full FIFO.
    rdc0 = rd_count;
    rsp_ready = 0;
    gen(4'd2, 11'h10);
    gen(4'd2, 11'h11);
    check_eq("full_ready", 128'(req_ready), 128'd0);
    fork
      gen(4'd2, 11'h12);
      begin
        repeat (4) @(posedge clk);
        #1;
        check_eq("stall_rd_count", 128'(rd_count), 128'(rdc0 + 2));
        rsp_ready = 1;
      end
    join
    drain();
    check_eq("bp_rd_count", 128'(rd_count), 128'(rdc0 + 3));

    // Zero seed loads all-ones; seed and GEN colliding on one channel.
    seed(4'd3, 32'd0);
    gen(4'd3, 11'h30);
    check_eq("seed0_gen", rsp_data, RESET_WORD);
    drain();
    seed_we = 1; seed_id = 4'd3; seed_val = 32'h12345678;
    gen(4'd3, 11'h31);
    seed_we = 0;
    check_eq("seed_gen_old", rsp_data, gen_word(32'hFFFFFFF6));
    drain();
    gen(4'd3, 11'h32);
    check_eq("seed_gen_new", rsp_data, gen_word(32'h12345678));
    drain();

    // Channel isolation.
    seed(4'd0, 32'hFFFFFFFF);
    gen(4'd0, 11'h40);
    check_eq("iso_first", rsp_data, RESET_WORD);
    drain();
    gen(4'd1, 11'h41);
    drain();
    gen(4'd0, 11'h42);
    check_eq("iso_second", rsp_data, gen_word(32'hFFFFFFF6));
    drain();

    // Asynchronous reset with responses pending.
    rsp_ready = 0;
    gen(4'd4, 11'h50);
    gen(4'd4, 11'h51);
    #2 rst_n = 0;
    #1;
    check_eq("async_rst_valid", 128'(rsp_valid), 128'd0);
    check_eq("async_rst_rd", 128'(rd_count), 128'd0);
    @(posedge clk); #1;
    rst_n = 1;
    rsp_ready = 1;
    @(posedge clk); #1;

`ifdef UR_ERR_INJ_EN
    err_inject = 1; err_type = 4'd1; err_addr_mask = 11'h00F;
    @(posedge clk); #1;
    err_inject = 0;
    gen(4'd0, 11'h20);
    check_eq("err_inv", rsp_data, INV_WORD);
    check_eq("err_cnt1", 128'(err_count), 128'd1);
    drain();
    gen(4'd0, 11'h21);
    check_eq("err_skip", rsp_data, gen_word(32'hFFFFFFF6));
    check_eq("err_cnt_hold", 128'(err_count), 128'd1);
    drain();
`else
    gen(4'd0, 11'h20);
    check_eq("post_rst_gen", rsp_data, RESET_WORD);
    drain();
`endif

    // Randomized traffic with random backpressure and seeding.
    rand_done = 0;
    fork
      begin
        for (int n = 0; n < 300; n++) begin
          if ($urandom_range(0, 9) == 0) begin
            seed_we = 1;
            seed_id = 4'($urandom_range(0, 15));
            seed_val = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
          end
`ifdef UR_ERR_INJ_EN
          if ($urandom_range(0, 19) == 0) begin
            err_inject = 1; err_type = 4'($urandom_range(0, 7));
            err_addr_mask = 11'($urandom_range(0, 15));
          end
`endif
          send(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
               11'($urandom_range(0, 15)), {$urandom, $urandom, $urandom, $urandom},
               16'($urandom));
          seed_we = 0;
`ifdef UR_ERR_INJ_EN
          err_inject = 0;
`endif
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        rand_done = 1;
      end
      begin
        for (int c = 0; c < 20000 && !rand_done; c++) begin
          @(posedge clk); #1;
          rsp_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    drain();
    repeat (2) @(posedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
